// File: rtl/tmr_scrub_pkg.sv
// Shared types and constants for the TMR scrub controller.
//   scrub_state_t : scrubber FSM encoding
//   COPY_A/B/C    : index of each redundant copy in the storage array
package tmr_scrub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      READ = 2'd2,
      FIX  = 2'd3
   } scrub_state_t;

   localparam int         NUM_COPIES = 3;
   localparam logic [1:0] COPY_A     = 2'd0;
   localparam logic [1:0] COPY_B     = 2'd1;
   localparam logic [1:0] COPY_C     = 2'd2;

endpackage

// File: rtl/tmr_word_voter.sv
// Bitwise 2-of-3 majority voter for one word.
//   a, b, c  : the three copies of the word
//   voted    : per-bit majority
//   mismatch : high when any bit differs between the copies
module tmr_word_voter #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] voted,
   output logic             mismatch
);

   assign voted    = (a & b) | (a & c) | (b & c);
   assign mismatch = |((a ^ b) | (a ^ c));

endmodule

// File: rtl/tmr_scrub_controller.sv
// Triplicated register array with a voted user port and a background scrubber.
//   clk, rst                  : clock, async active-high reset (also clears the array)
//   wr_en/wr_addr/wr_data     : user write, lands in all three copies, never stalls
//   rd_en/rd_addr             : user read request
//   rd_data/rd_valid          : voted read data, one cycle after rd_en
//   scrub_en, scrub_period    : scrubber enable and idle cycles between steps
//   err_clr                   : clears err_count and err_flag (wins over an increment)
//   err_count, err_flag       : saturating correction count, sticky correction flag
//   scrub_busy                : scrubber in READ or FIX
//   inj_en/inj_copy/inj_addr/inj_mask : XOR fault injection into one copy
//
// state | meaning
// IDLE  | scrubbing disabled, pointer retained
// WAIT  | period timer counting down to zero
// READ  | vote word at pointer, latch result and mismatch
// FIX   | write back if corrected and not overtaken by a user write, advance pointer
module tmr_scrub_controller
   import tmr_scrub_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   parameter  int PER_W = 16,
   parameter  int CNT_W = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             scrub_en,
   input  logic [PER_W-1:0] scrub_period,
   input  logic             err_clr,
   output logic [CNT_W-1:0] err_count,
   output logic             err_flag,
   output logic             scrub_busy,
   input  logic             inj_en,
   input  logic [1:0]       inj_copy,
   input  logic [AW-1:0]    inj_addr,
   input  logic [WIDTH-1:0] inj_mask
);

   logic [WIDTH-1:0] mem     [NUM_COPIES][DEPTH];
   logic [WIDTH-1:0] mem_nxt [NUM_COPIES][DEPTH];

   scrub_state_t     state, state_nxt;
   logic [PER_W-1:0] tmr, tmr_nxt;
   logic [AW-1:0]    ptr, ptr_nxt;
   logic [WIDTH-1:0] vote_q;
   logic             mism_q;
   logic             hit_q;
   logic             wr_ptr_hit;
   logic             fix_we;

   logic [WIDTH-1:0] rd_vote;
   logic             rd_mism_unused;
   logic [WIDTH-1:0] sc_vote;
   logic             sc_mism;

   tmr_word_voter #(.WIDTH(WIDTH)) u_rd_voter (
      .a        (mem[COPY_A][rd_addr]),
      .b        (mem[COPY_B][rd_addr]),
      .c        (mem[COPY_C][rd_addr]),
      .voted    (rd_vote),
      .mismatch (rd_mism_unused)
   );

   tmr_word_voter #(.WIDTH(WIDTH)) u_sc_voter (
      .a        (mem[COPY_A][ptr]),
      .b        (mem[COPY_B][ptr]),
      .c        (mem[COPY_C][ptr]),
      .voted    (sc_vote),
      .mismatch (sc_mism)
   );

   assign wr_ptr_hit = wr_en && (wr_addr == ptr);
   assign scrub_busy = (state == READ) || (state == FIX);

   // A user write seen in READ (hit_q) or FIX makes the latched vote stale.
   assign fix_we = (state == FIX) && mism_q && !hit_q && !wr_ptr_hit;

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            tmr_nxt = '0;
            if (scrub_en) begin
               state_nxt = WAIT;
               tmr_nxt   = scrub_period;
            end
         end
         WAIT: begin
            if (!scrub_en) begin
               state_nxt = IDLE;
               tmr_nxt   = '0;
            end else if (tmr == '0) begin
               state_nxt = READ;
            end else begin
               tmr_nxt = tmr - 1'b1;
            end
         end
         READ: state_nxt = FIX;
         FIX: begin
            ptr_nxt = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
            if (scrub_en) begin
               state_nxt = WAIT;
               tmr_nxt   = scrub_period;
            end else begin
               state_nxt = IDLE;
               tmr_nxt   = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         tmr   <= '0;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         tmr   <= tmr_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vote_q <= '0;
         mism_q <= 1'b0;
         hit_q  <= 1'b0;
      end else if (state == READ) begin
         vote_q <= sc_vote;
         mism_q <= sc_mism;
         hit_q  <= wr_ptr_hit;
      end
   end

   // Priority, lowest to highest: scrub writeback, injection, user write.
   always_comb begin
      mem_nxt = mem;
      if (fix_we) begin
         for (int c = 0; c < NUM_COPIES; c++) mem_nxt[c][ptr] = vote_q;
      end
      if (inj_en && (inj_copy != 2'd3) && !(wr_en && (wr_addr == inj_addr))) begin
         mem_nxt[inj_copy][inj_addr] = mem_nxt[inj_copy][inj_addr] ^ inj_mask;
      end
      if (wr_en) begin
         for (int c = 0; c < NUM_COPIES; c++) mem_nxt[c][wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) mem <= '{default: '0};
      else     mem <= mem_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_data <= rd_vote;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
         err_flag  <= 1'b0;
      end else if (err_clr) begin
         err_count <= '0;
         err_flag  <= 1'b0;
      end else if (fix_we) begin
         if (err_count != {CNT_W{1'b1}}) err_count <= err_count + 1'b1;
         err_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tmr_scrub_controller.sv
// Directed self-checking bench for tmr_scrub_controller (WIDTH=8, DEPTH=16).
module tb_tmr_scrub_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_addr = '0;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        scrub_en = 1'b0;
   logic [15:0] scrub_period = '0;
   logic        err_clr = 1'b0;
   logic [7:0]  err_count;
   logic        err_flag;
   logic        scrub_busy;
   logic        inj_en = 1'b0;
   logic [1:0]  inj_copy = '0;
   logic [3:0]  inj_addr = '0;
   logic [7:0]  inj_mask = '0;

   int n_checks = 0;
   int n_errors = 0;

   tmr_scrub_controller #(.WIDTH(8), .DEPTH(16), .PER_W(16), .CNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .scrub_en     (scrub_en),
      .scrub_period (scrub_period),
      .err_clr      (err_clr),
      .err_count    (err_count),
      .err_flag     (err_flag),
      .scrub_busy   (scrub_busy),
      .inj_en       (inj_en),
      .inj_copy     (inj_copy),
      .inj_addr     (inj_addr),
      .inj_mask     (inj_mask)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic do_inject(input logic [1:0] cp, input logic [3:0] a, input logic [7:0] m);
      inj_en = 1'b1; inj_copy = cp; inj_addr = a; inj_mask = m;
      @(negedge clk);
      inj_en = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
      rd_en = 1'b1; rd_addr = a;
      @(negedge clk);
      rd_en = 1'b0;
      check({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check(tag, 32'(rd_data), 32'(exp));
   endtask

   // Returns at the negedge that falls inside a FIX cycle (second busy cycle).
   task automatic wait_fix(input string tag);
      bit prev;
      bit found;
      prev  = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (prev && scrub_busy) found = 1'b1;
         prev = scrub_busy;
      end
      check(tag, 32'(found), 32'd1);
   endtask

   // Scrub off, inject n single-copy faults, then one full sweep with scrub on.
   task automatic sat_round(input int n, input int r);
      scrub_en = 1'b0;
      repeat (4) @(negedge clk);
      for (int a = 0; a < n; a++) do_inject(2'(r % 3), 4'(a), 8'(1 << (r % 8)));
      scrub_en = 1'b1;
      repeat (60) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  nb;
      bit  found;

      // reset values
      #1 rst = 1'b1;
      #2;
      check("rst_rd_data",   32'(rd_data),    32'd0);
      check("rst_rd_valid",  32'(rd_valid),   32'd0);
      check("rst_err_count", 32'(err_count),  32'd0);
      check("rst_err_flag",  32'(err_flag),   32'd0);
      check("rst_busy",      32'(scrub_busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      read_check("rd5_reset", 4'd5, 8'h00);
      @(negedge clk);
      check("rd_valid_low", 32'(rd_valid),  32'd0);
      check("err_cnt_zero", 32'(err_count), 32'd0);

      // write / read / inject into one copy
      do_write(4'd3, 8'hA5);
      read_check("rd3_a5", 4'd3, 8'hA5);
      do_inject(2'd1, 4'd3, 8'hFF);
      read_check("rd3_injb", 4'd3, 8'hA5);

      // same-cycle read+write returns the old voted word
      rd_en = 1'b1; rd_addr = 4'd3;
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h11;
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
      check("rw_same_old", 32'(rd_data), 32'h A5);
      read_check("rd3_new", 4'd3, 8'h11);

      // injection dropped under a same-address write; copy 3 is a no-op
      wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h22;
      inj_en = 1'b1; inj_copy = 2'd0; inj_addr = 4'd4; inj_mask = 8'hFF;
      @(negedge clk);
      wr_en = 1'b0; inj_en = 1'b0;
      do_inject(2'd1, 4'd4, 8'hFF);
      do_inject(2'd3, 4'd4, 8'hFF);
      read_check("inj_drop_nop", 4'd4, 8'h22);
      do_write(4'd4, 8'h22);

      // scrub with period 0 corrects one word
      do_inject(2'd2, 4'd7, 8'h01);
      scrub_en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 48 && !found; i++) begin
         @(negedge clk);
         if (err_count == 8'd1) found = 1'b1;
      end
      check("scrub_found", 32'(found), 32'd1);
      check("scrub_cnt1",  32'(err_count), 32'd1);
      check("scrub_flag1", 32'(err_flag),  32'd1);
      read_check("rd7_fixed", 4'd7, 8'h00);

      do_inject(2'd3, 4'd7, 8'h01);
      nb = 0;
      repeat (48) begin
         @(negedge clk);
         if (scrub_busy) nb++;
      end
      check("busy_p0",       32'(nb),        32'd32);
      check("no_reinc_cnt",  32'(err_count), 32'd1);

      scrub_period = 16'd2;
      repeat (10) @(negedge clk);
      nb = 0;
      repeat (50) begin
         @(negedge clk);
         if (scrub_busy) nb++;
      end
      check("busy_p2", 32'(nb), 32'd20);
      scrub_period = 16'd0;

      // async reset during FIX
      read_check("rd3_pre_rst", 4'd3, 8'h11);
      wait_fix("fix_before_rst");
      rst = 1'b1;
      scrub_en = 1'b0;
      #1;
      check("arst_rd_data",   32'(rd_data),    32'd0);
      check("arst_rd_valid",  32'(rd_valid),   32'd0);
      check("arst_err_count", 32'(err_count),  32'd0);
      check("arst_err_flag",  32'(err_flag),   32'd0);
      check("arst_busy",      32'(scrub_busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      read_check("rd3_cleared", 4'd3, 8'h00);

      // user write to the scrubbed address during READ (pointer restarted at 0)
      do_inject(2'd0, 4'd2, 8'h0F);
      scrub_en = 1'b1;
      repeat (8) @(negedge clk);
      check("busy_in_read2", 32'(scrub_busy), 32'd1);
      do_write(4'd2, 8'h3C);
      repeat (60) @(negedge clk);
      check("conflict_cnt",  32'(err_count), 32'd0);
      check("conflict_flag", 32'(err_flag),  32'd0);
      read_check("rd2_user", 4'd2, 8'h3C);

      // saturation
      for (int r = 0; r < 15; r++) sat_round(16, r);
      check("sat_240", 32'(err_count), 32'd240);
      sat_round(15, 15);
      check("sat_255", 32'(err_count), 32'd255);
      sat_round(1, 16);
      check("sat_hold",      32'(err_count), 32'd255);
      check("sat_flag",      32'(err_flag),  32'd1);

      // err_clr in the same cycle as a correction
      scrub_en = 1'b0;
      repeat (4) @(negedge clk);
      for (int a = 0; a < 16; a++) do_inject(2'd1, 4'(a), 8'h80);
      scrub_en = 1'b1;
      wait_fix("fix_for_clr");
      err_clr  = 1'b1;
      scrub_en = 1'b0;
      @(negedge clk);
      err_clr = 1'b0;
      check("clr_cnt",  32'(err_count), 32'd0);
      check("clr_flag", 32'(err_flag),  32'd0);
      repeat (5) @(negedge clk);
      check("clr_cnt_hold", 32'(err_count),  32'd0);
      check("idle_busy",    32'(scrub_busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
